// File: rtl/layer_bias_rx_if.sv
// Bias-stream load and accumulator/bias-add bus for layer_bias_rx.
// master drives load/bias/acc requests; slave (the receiver) drives ready/status/results.
interface layer_bias_rx_if #(
    parameter int CH_NUM = 32,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(CH_NUM);

    logic                load_start;
    logic [2*DATA_W-1:0] bias_data;
    logic                bias_valid;
    logic                bias_last;
    logic                ready;
    logic                bias_done;
    logic                len_err;
    logic                acc_valid;
    logic [CW-1:0]       acc_ch;
    logic [DATA_W-1:0]   acc_data;
    logic                out_valid;
    logic [CW-1:0]       out_ch;
    logic [DATA_W-1:0]   out_data;
    logic                out_sat;

    modport master (
        output load_start, bias_data, bias_valid, bias_last,
        output acc_valid, acc_ch, acc_data,
        input  ready, bias_done, len_err,
        input  out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  load_start, bias_data, bias_valid, bias_last,
        input  acc_valid, acc_ch, acc_data,
        output ready, bias_done, len_err,
        output out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/layer_bias_rx.sv
// Unpacks a two-biases-per-beat stream into a CH_NUM-entry table, then adds bias[ch] to each acc.
// Optional macro BIAS_SAT_EN: clamp the sum to the signed DATA_W range and flag out_sat.
module layer_bias_rx #(
    parameter int CH_NUM = 32,
    parameter int DATA_W = 32
) (
    input  logic               sclk,
    input  logic               s_rst,
    layer_bias_rx_if.slave     bus,
    output logic [1:0]         o_dbg_state
);
    localparam int CW = $clog2(CH_NUM);
    localparam logic [CW-1:0] LAST_WPTR = CW'(CH_NUM / 2 - 1);

    // Bias stream handshake: a beat transfers on a rising sclk edge where
    // bias_valid && ready; bias_data/bias_last are only looked at on that edge.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd2} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_wptr;
    logic                r_len_err;
    logic [DATA_W-1:0]   r_bias [CH_NUM];
    logic                w_ready;
    logic                w_done;
    logic                w_accept;
    logic                w_final_beat;
    logic                w_start;
    logic [CW-1:0]       w_even_idx;
    logic [CW-1:0]       w_odd_idx;
    logic [DATA_W-1:0]   w_bias_sel;
    logic [DATA_W-1:0]   w_res;
    logic                w_ovf;
    logic                w_acc_take;
    logic                r_out_valid;
    logic [CW-1:0]       r_out_ch;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_sat;

    assign w_accept     = bus.bias_valid && w_ready;
    assign w_final_beat = bus.bias_last || (r_wptr == LAST_WPTR);
    assign w_start      = bus.load_start && (r_state != ST_LOAD);
    assign w_even_idx   = CW'({r_wptr, 1'b0});
    assign w_odd_idx    = CW'({r_wptr, 1'b1});

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.load_start) w_next_state = ST_LOAD;
            ST_LOAD: if (w_accept && w_final_beat) w_next_state = ST_DONE;
            ST_DONE: if (bus.load_start) w_next_state = ST_LOAD;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == ST_LOAD);
        w_done  = (r_state == ST_DONE);
    end

    // A mismatch between bias_last and the final slot flags both early and missing last.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_wptr    <= '0;
            r_len_err <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) r_bias[i] <= '0;
        end else if (w_start) begin
            r_wptr    <= '0;
            r_len_err <= 1'b0;
        end else if (w_accept) begin
            r_bias[w_even_idx] <= bus.bias_data[DATA_W-1:0];
            r_bias[w_odd_idx]  <= bus.bias_data[2*DATA_W-1:DATA_W];
            r_wptr             <= r_wptr + CW'(1);
            if (bus.bias_last != (r_wptr == LAST_WPTR)) r_len_err <= 1'b1;
        end
    end

    assign w_acc_take = bus.acc_valid && w_done;
    assign w_bias_sel = r_bias[bus.acc_ch];

`ifdef BIAS_SAT_EN
    logic [DATA_W:0] w_sum;
    always_comb begin
        w_sum = {bus.acc_data[DATA_W-1], bus.acc_data} + {w_bias_sel[DATA_W-1], w_bias_sel};
        w_ovf = w_sum[DATA_W] ^ w_sum[DATA_W-1];
        w_res = w_sum[DATA_W-1:0];
        if (w_ovf) w_res = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    always_comb begin
        w_ovf = 1'b0;
        w_res = bus.acc_data + w_bias_sel;
    end
`endif

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= w_acc_take;
            if (w_acc_take) begin
                r_out_ch   <= bus.acc_ch;
                r_out_data <= w_res;
                r_out_sat  <= w_ovf;
            end
        end
    end

    assign bus.ready     = w_ready;
    assign bus.bias_done = w_done;
    assign bus.len_err   = r_len_err;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign o_dbg_state   = r_state;
endmodule
